// File: rtl/config_frame_sequencer.sv
// Configuration frame sequencer: hunts for a sync word in the config write stream, then loads
// a frame address plus NUMBER_OF_ROWS data words per frame and drives RowSelect and a stretched commit strobe.
module config_frame_sequencer #(
    parameter int          NUMBER_OF_ROWS     = 16,
    parameter int          ROW_SELECT_WIDTH   = 5,
    parameter int          FRAME_BITS_PER_ROW = 32,
    parameter logic [31:0] SYNC_WORD          = 32'hFAB0FAB1,
    parameter int          DESYNC_FLAG        = 20,
    parameter int          CHECK_FLAG         = 21,
    parameter int          STROBE_CYCLES      = 2,
    parameter int          FRAME_COUNT_WIDTH  = 16
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic [31:0]                   WriteData,
    input  logic                          WriteStrobe,
    input  logic                          FSM_Reset,
    output logic [FRAME_BITS_PER_ROW-1:0] FrameAddressRegister,
    output logic                          LongFrameStrobe,
    output logic [ROW_SELECT_WIDTH-1:0]   RowSelect,
    output logic                          Synced,
    output logic                          ConfigError,
    output logic [FRAME_COUNT_WIDTH-1:0]  FrameCount,
    output logic [1:0]                    DebugState
);

    localparam int SCW = (STROBE_CYCLES < 2) ? 1 : $clog2(STROBE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_UNSYNCED = 2'd0,
        S_SYNCHED  = 2'd1,
        S_WRITE    = 2'd2,
        S_CHECK    = 2'd3
    } state_t;

    state_t                          state_q, state_d;
    logic [ROW_SELECT_WIDTH-1:0]     row_cnt_q, row_cnt_d;
    logic [31:0]                     checksum_q, checksum_d;
    logic [FRAME_BITS_PER_ROW-1:0]   frame_addr_q, frame_addr_d;
    logic                            frame_strobe_q, frame_strobe_d;
    logic [SCW-1:0]                  strobe_cnt_q, strobe_cnt_d;
    logic                            long_strobe_q, long_strobe_d;
    logic                            cfg_err_q, cfg_err_d;
    logic [FRAME_COUNT_WIDTH-1:0]    frame_cnt_q, frame_cnt_d;
    logic                            fsm_reset_q;
    logic                            fsm_reset_rise;

    // WriteStrobe is a valid-only qualifier: there is no backpressure, every strobed word is
    // consumed in the cycle it is presented, and cycles without WriteStrobe leave the FSM untouched.
    assign fsm_reset_rise = FSM_Reset && !fsm_reset_q;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q        <= S_UNSYNCED;
            row_cnt_q      <= '0;
            checksum_q     <= '0;
            frame_addr_q   <= '0;
            frame_strobe_q <= 1'b0;
            strobe_cnt_q   <= '0;
            long_strobe_q  <= 1'b0;
            cfg_err_q      <= 1'b0;
            frame_cnt_q    <= '0;
            fsm_reset_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            row_cnt_q      <= row_cnt_d;
            checksum_q     <= checksum_d;
            frame_addr_q   <= frame_addr_d;
            frame_strobe_q <= frame_strobe_d;
            strobe_cnt_q   <= strobe_cnt_d;
            long_strobe_q  <= long_strobe_d;
            cfg_err_q      <= cfg_err_d;
            frame_cnt_q    <= frame_cnt_d;
            fsm_reset_q    <= FSM_Reset;
        end
    end

    always_comb begin
        state_d        = state_q;
        row_cnt_d      = row_cnt_q;
        checksum_d     = checksum_q;
        frame_addr_d   = frame_addr_q;
        frame_strobe_d = 1'b0;
        strobe_cnt_d   = strobe_cnt_q;
        cfg_err_d      = cfg_err_q;
        frame_cnt_d    = frame_cnt_q;

        if (frame_strobe_q) begin
            strobe_cnt_d = SCW'(STROBE_CYCLES);
        end else if (strobe_cnt_q != '0) begin
            strobe_cnt_d = strobe_cnt_q - SCW'(1);
        end

        // A soft resync wins over whatever word arrives in the same cycle; the address is kept.
        if (fsm_reset_rise) begin
            state_d      = S_UNSYNCED;
            row_cnt_d    = '0;
            checksum_d   = '0;
            strobe_cnt_d = '0;
            cfg_err_d    = 1'b0;
            frame_cnt_d  = '0;
        end else if (WriteStrobe) begin
            case (state_q)
                S_UNSYNCED: begin
                    if (WriteData == SYNC_WORD) begin
                        state_d    = S_SYNCHED;
                        checksum_d = '0;
                    end
                end
                S_SYNCHED: begin
                    if (WriteData[DESYNC_FLAG]) begin
                        state_d = S_UNSYNCED;
                    end else if (WriteData[CHECK_FLAG]) begin
                        state_d = S_CHECK;
                    end else begin
                        frame_addr_d = WriteData[FRAME_BITS_PER_ROW-1:0];
                        row_cnt_d    = ROW_SELECT_WIDTH'(NUMBER_OF_ROWS);
                        state_d      = S_WRITE;
                    end
                end
                S_WRITE: begin
                    checksum_d = checksum_q + WriteData;
                    row_cnt_d  = row_cnt_q - ROW_SELECT_WIDTH'(1);
                    if (row_cnt_q == ROW_SELECT_WIDTH'(1)) begin
                        frame_strobe_d = 1'b1;
                        frame_cnt_d    = frame_cnt_q + FRAME_COUNT_WIDTH'(1);
                        state_d        = S_SYNCHED;
                    end
                end
                S_CHECK: begin
                    if (WriteData == checksum_q) begin
                        checksum_d = '0;
                        state_d    = S_SYNCHED;
                    end else begin
                        cfg_err_d = 1'b1;
                        state_d   = S_UNSYNCED;
                    end
                end
                default: state_d = S_UNSYNCED;
            endcase
        end

        long_strobe_d = (strobe_cnt_d != '0);
    end

    assign RowSelect            = (WriteStrobe && state_q == S_WRITE) ? row_cnt_q : '1;
    assign FrameAddressRegister = frame_addr_q;
    assign LongFrameStrobe      = long_strobe_q;
    assign Synced               = (state_q != S_UNSYNCED);
    assign ConfigError          = cfg_err_q;
    assign FrameCount           = frame_cnt_q;
    assign DebugState           = state_q;

endmodule
